pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
Parametrised hazard and forwarding controller for the 5-stage F/D/E/M/W core pipeline. The previous pipeline had no hazard handling.
- Keeps a shadow pipeline of per-instruction control info for the E, M and W stages.
- Detects RAW, load-use and branch hazards.
- Drives the stall/flush enables of the pipeline registers and the operand forwarding selects.
- Generalised to NSRC source operands per instruction and a selectable no-forwarding mode.

Parameters:
RA_W, 4, register address width
NSRC, 2, source operands per instruction (3 for vector ops)
PC_REG, 15, register index that reads PC+8; excluded from all hazard checks
FWD_EN, 1, 1 = forward and stall only on load-use; 0 = no forwarding, stall until producer retires

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the rising clk edge)
d_valid  in  1  Decode holds a real instruction
d_ra  in  NSRC*RA_W  Decode source addresses, operand i at [i*RA_W +: RA_W]
d_used  in  NSRC  operand i actually read
d_wa  in  RA_W  destination register
d_regw  in  1  instruction writes the register file
d_load  in  1  instruction is a load (MemtoReg)
d_pcs  in  1  instruction writes PC
e_condex  in  1  condition-check result for the E-stage instruction
stall_f  out  1  hold PC register
stall_d  out  1  hold Fetch-Decode register
flush_d  out  1  clear Fetch-Decode register
flush_e  out  1  load bubble into Decode-Exe register
fwd_e  out  2*NSRC  E operand i select: 00 regfile/pipe, 01 ResultW, 10 ALUOutM
byp_d  out  NSRC  Decode operand i must take ResultW (W writes it this cycle)
redirect  out  1  taken PC write in E; PC mux selects the E result

Behaviour:
- Shadow state per stage S in {E,M,W}: valid, wa, regw, load, pcs; E additionally holds ra[NSRC] and used[NSRC].
- Reset (reset==0 at clk edge): all valid bits cleared. All outputs are 0 from the following cycle; outputs are combinational from state plus inputs, so with valid=0 they evaluate to 0.
- Reset mid-stall or mid-flush takes precedence and empties the shadow pipe.
- Match rule: match(S, a) = S.valid & S.regw & S.wa==a & a!=PC_REG, applied only to used operands.
- Forwarding (FWD_EN=1):
  - fwd_e[i] = 10 if match(M, E.ra[i]); else 01 if match(W, E.ra[i]); else 00. M has priority as the newer producer.
  - byp_d[i] = d_valid & d_used[i] & match(W, d_ra[i]).
- Load-use stall (FWD_EN=1):
  - Condition: d_valid & any used i with match(E, d_ra[i]) & E.load.
  - Effect: stall_f = stall_d = flush_e = 1.
  - Uses unqualified E.regw (not gated by e_condex).
  - Exactly 1 stall cycle per load-use pair.
- FWD_EN=0:
  - fwd_e and byp_d are tied to 0.
  - Stall while any used D source matches E, M or W; up to 3 stall cycles.
- Branch: redirect = E.valid & E.pcs & e_condex.
  - On redirect: flush_d = flush_e = 1, stall_f = stall_d = 0.
  - Redirect has priority over any stall, since the stalled D instruction is squashed.
  - Branch penalty is 2 cycles.
- Stage advance at each clk edge (reset==1):
  - E ← bubble (valid=0) if flush_e.
  - Otherwise E ← {d_valid, d_wa, d_regw, d_load, d_pcs, d_ra, d_used}.
  - M ← E, with regw and pcs ANDed with e_condex.
  - W ← M.
  - M and W always advance; stalls affect only F, D and E.
- d_valid=0: no stall and no bypass generated from D.
- A non-register-writing producer never creates a hazard.
- Writes to PC_REG are handled only via pcs, never via forwarding.

Test Plan:
- ADD r1 then SUB r2,r1,r3 back-to-back -> SUB in E sees fwd_e[0]=10; no stall.
- ADD r1, NOP, ORR r4,r1,r1 -> ORR in E sees fwd_e[1:0]=01 and fwd_e[3:2]=01. One cycle earlier, byp_d is not required because ADD is in M while ORR is in D.
- LDR r5 then ADD r6,r5,#1 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle, then fwd_e[0]=01; ADD completes 1 cycle late.
- Taken B in E (d_pcs=1, e_condex=1) with a load-use condition present in D -> redirect=1, flush_d=flush_e=1, stall_f=0. Same branch with e_condex=0 -> redirect=0 and nothing is flushed.
- FWD_EN=0: ADD r1 then SUB r2,r1,r1 -> 3 consecutive stall cycles, fwd_e=0. A source of r15 (PC_REG) after a write to r15 -> no stall in either mode.
- Reset pulled low during a load-use stall -> next cycle all outputs 0 and valid bits clear. A subsequent dependent pair behaves as in the first scenario.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard detection and operand forwarding control for the F/D/E/M/W pipeline.
// Keeps shadow control info for the E, M and W stages and detects RAW, load-use and branch hazards.
// Ports:
//   clk, reset (synchronous, active-low)
//   d_valid, d_ra, d_used, d_wa, d_regw, d_load, d_pcs : Decode-stage instruction info
//   e_condex                                          : condition result for the E-stage instruction
//   stall_f, stall_d, flush_d, flush_e                : pipeline register enables
//   fwd_e                                             : per-operand E forwarding select (00 pipe, 01 ResultW, 10 ALUOutM)
//   byp_d                                             : per-operand Decode bypass from ResultW
//   redirect                                          : taken PC write in E
module pipe_hazard_unit #(
    parameter int RA_W   = 4,
    parameter int NSRC   = 2,
    parameter int PC_REG = 15,
    parameter int FWD_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 d_valid,
    input  logic [NSRC*RA_W-1:0] d_ra,
    input  logic [NSRC-1:0]      d_used,
    input  logic [RA_W-1:0]      d_wa,
    input  logic                 d_regw,
    input  logic                 d_load,
    input  logic                 d_pcs,
    input  logic                 e_condex,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic [2*NSRC-1:0]    fwd_e,
    output logic [NSRC-1:0]      byp_d,
    output logic                 redirect
);
    logic                 e_valid, e_regw, e_load, e_pcs;
    logic [RA_W-1:0]      e_wa;
    logic [NSRC*RA_W-1:0] e_ra;
    logic [NSRC-1:0]      e_used;
    logic                 m_valid, m_regw;
    logic [RA_W-1:0]      m_wa;
    logic                 w_valid, w_regw;
    logic [RA_W-1:0]      w_wa;
    logic                 stall;

    // PC_REG reads PC+8, so it never participates in register hazards
    function automatic logic hit(input logic v, input logic r, input logic [RA_W-1:0] wa,
                                 input logic [RA_W-1:0] a);
        return v & r & (wa == a) & (a != RA_W'(PC_REG));
    endfunction

    always_comb begin
        stall = 1'b0;
        fwd_e = '0;
        byp_d = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (FWD_EN != 0) begin
                stall = stall | (d_valid & d_used[i] & e_load &
                                 hit(e_valid, e_regw, e_wa, d_ra[i*RA_W +: RA_W]));
                byp_d[i] = d_valid & d_used[i] & hit(w_valid, w_regw, w_wa, d_ra[i*RA_W +: RA_W]);
                // M is the newer producer, so it wins over W
                fwd_e[2*i +: 2] = !(e_valid && e_used[i]) ? 2'b00 :
                                  hit(m_valid, m_regw, m_wa, e_ra[i*RA_W +: RA_W]) ? 2'b10 :
                                  hit(w_valid, w_regw, w_wa, e_ra[i*RA_W +: RA_W]) ? 2'b01 : 2'b00;
            end else begin
                stall = stall | (d_valid & d_used[i] &
                                 (hit(e_valid, e_regw, e_wa, d_ra[i*RA_W +: RA_W]) |
                                  hit(m_valid, m_regw, m_wa, d_ra[i*RA_W +: RA_W]) |
                                  hit(w_valid, w_regw, w_wa, d_ra[i*RA_W +: RA_W])));
            end
        end
    end

    // a taken branch squashes the stalled D instruction, so redirect overrides stall
    assign redirect = e_valid & e_pcs & e_condex;
    assign stall_f  = stall & ~redirect;
    assign stall_d  = stall & ~redirect;
    assign flush_d  = redirect;
    assign flush_e  = stall | redirect;

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_valid <= 1'b0;
            m_valid <= 1'b0;
            w_valid <= 1'b0;
        end else begin
            e_valid <= d_valid & ~flush_e;
            e_wa    <= d_wa;
            e_regw  <= d_regw;
            e_load  <= d_load;
            e_pcs   <= d_pcs;
            e_ra    <= d_ra;
            e_used  <= d_used;
            // a failed condition turns the E instruction into a non-writer downstream
            m_valid <= e_valid;
            m_wa    <= e_wa;
            m_regw  <= e_regw & e_condex;
            w_valid <= m_valid;
            w_wa    <= m_wa;
            w_regw  <= m_regw;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed vector bench for pipe_hazard_unit in forwarding and no-forwarding modes.
module tb_pipe_hazard_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [7:0] d_ra;
    logic [1:0] d_used;
    logic [3:0] d_wa;
    logic       d_regw, d_load, d_pcs, e_condex;

    logic       f_stall_f, f_stall_d, f_flush_d, f_flush_e, f_redirect;
    logic [3:0] f_fwd_e;
    logic [1:0] f_byp_d;
    logic       n_stall_f, n_stall_d, n_flush_d, n_flush_e, n_redirect;
    logic [3:0] n_fwd_e;
    logic [1:0] n_byp_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.FWD_EN(1)) u_fwd (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_ra(d_ra), .d_used(d_used),
        .d_wa(d_wa), .d_regw(d_regw), .d_load(d_load), .d_pcs(d_pcs), .e_condex(e_condex),
        .stall_f(f_stall_f), .stall_d(f_stall_d), .flush_d(f_flush_d), .flush_e(f_flush_e),
        .fwd_e(f_fwd_e), .byp_d(f_byp_d), .redirect(f_redirect)
    );

    pipe_hazard_unit #(.FWD_EN(0)) u_nf (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_ra(d_ra), .d_used(d_used),
        .d_wa(d_wa), .d_regw(d_regw), .d_load(d_load), .d_pcs(d_pcs), .e_condex(e_condex),
        .stall_f(n_stall_f), .stall_d(n_stall_d), .flush_d(n_flush_d), .flush_e(n_flush_e),
        .fwd_e(n_fwd_e), .byp_d(n_byp_d), .redirect(n_redirect)
    );

    // expected layout: {stall_f, stall_d, flush_d, flush_e, fwd_e[3:0], byp_d[1:0], redirect}
    typedef struct packed {
        logic        rst;
        logic        dv;
        logic [7:0]  ra;
        logic [1:0]  used;
        logic [3:0]  wa;
        logic        regw, load, pcs, cx;
        logic [10:0] exp;
    } vec_t;

    localparam logic [10:0] Z     = 11'b0;
    localparam logic [10:0] STALL = {4'b1101, 4'b0000, 2'b00, 1'b0};
    localparam logic [10:0] REDIR = {4'b0011, 4'b0000, 2'b00, 1'b1};
    localparam logic [10:0] FM0   = {4'b0000, 4'b0010, 2'b00, 1'b0};
    localparam logic [10:0] FW0   = {4'b0000, 4'b0001, 2'b00, 1'b0};
    localparam logic [10:0] FW01  = {4'b0000, 4'b0101, 2'b00, 1'b0};
    localparam logic [10:0] BYP0  = {4'b0000, 4'b0000, 2'b01, 1'b0};

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, input logic dv, input logic [7:0] ra,
                               input logic [1:0] used, input logic [3:0] wa, input logic regw,
                               input logic load, input logic pcs, input logic cx,
                               input logic [10:0] exp);
        return '{rst, dv, ra, used, wa, regw, load, pcs, cx, exp};
    endfunction

    task automatic drive(input logic dv, input logic [7:0] ra, input logic [1:0] used,
                         input logic [3:0] wa, input logic regw, input logic load);
        d_valid = dv; d_ra = ra; d_used = used; d_wa = wa; d_regw = regw; d_load = load;
        d_pcs = 1'b0; e_condex = 1'b1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, got, exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [10:0] got;
        int n;
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));      // reset state
        // ADD r1 ; SUB r2,r1,r3 -> M forward on operand 0
        tbl.push_back(v(1, 1, 8'h32, 2'b11, 1, 1, 0, 0, 1, Z));
        tbl.push_back(v(1, 1, 8'h31, 2'b11, 2, 1, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, FM0));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        // ADD r1 ; NOP ; ORR r4,r1,r1 -> W forward on both operands
        tbl.push_back(v(1, 1, 8'h32, 2'b11, 1, 1, 0, 0, 1, Z));
        tbl.push_back(v(1, 1, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 1, 8'h11, 2'b11, 4, 1, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, FW01));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        // reader of r4 in D while ORR sits in W -> Decode bypass
        tbl.push_back(v(1, 1, 8'h04, 2'b01, 0, 0, 0, 0, 1, BYP0));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        // LDR r5 ; ADD r6,r5 -> one stall cycle then W forward
        tbl.push_back(v(1, 1, 8'h02, 2'b01, 5, 1, 1, 0, 1, Z));
        tbl.push_back(v(1, 1, 8'h05, 2'b01, 6, 1, 0, 0, 1, STALL));
        tbl.push_back(v(1, 1, 8'h05, 2'b01, 6, 1, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, FW0));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        // PC-writing load in E taken, dependent reader in D -> redirect wins
        tbl.push_back(v(1, 1, 8'h02, 2'b01, 5, 1, 1, 1, 1, Z));
        tbl.push_back(v(1, 1, 8'h05, 2'b01, 6, 1, 0, 0, 1, REDIR));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        // same branch not taken -> nothing flushed, and its write is dropped downstream
        tbl.push_back(v(1, 1, 8'h02, 2'b01, 5, 1, 1, 1, 1, Z));
        tbl.push_back(v(1, 1, 8'h07, 2'b01, 6, 1, 0, 0, 0, Z));
        tbl.push_back(v(1, 1, 8'h05, 2'b01, 8, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        // LDR r15 ; reader of r15 -> PC_REG never hazards
        tbl.push_back(v(1, 1, 8'h02, 2'b01, 15, 1, 1, 0, 1, Z));
        tbl.push_back(v(1, 1, 8'hFF, 2'b11, 3, 1, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 1, 8'h0F, 2'b01, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        // load-use pattern with d_valid=0 -> no stall
        tbl.push_back(v(1, 1, 8'h02, 2'b01, 5, 1, 1, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h05, 2'b01, 6, 1, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        // reset asserted during a load-use stall, then the pair again
        tbl.push_back(v(1, 1, 8'h02, 2'b01, 5, 1, 1, 0, 1, Z));
        tbl.push_back(v(0, 1, 8'h05, 2'b01, 6, 1, 0, 0, 1, STALL));
        tbl.push_back(v(1, 1, 8'h05, 2'b01, 6, 1, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));
        tbl.push_back(v(1, 1, 8'h02, 2'b01, 5, 1, 1, 0, 1, Z));
        tbl.push_back(v(1, 1, 8'h05, 2'b01, 6, 1, 0, 0, 1, STALL));
        tbl.push_back(v(1, 1, 8'h05, 2'b01, 6, 1, 0, 0, 1, Z));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, FW0));
        tbl.push_back(v(1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 1, Z));

        reset = 1'b0;
        drive(0, 8'h00, 2'b00, 0, 0, 0);
        step();
        step();
        foreach (tbl[k]) begin
            reset = tbl[k].rst;
            d_valid = tbl[k].dv; d_ra = tbl[k].ra; d_used = tbl[k].used; d_wa = tbl[k].wa;
            d_regw = tbl[k].regw; d_load = tbl[k].load; d_pcs = tbl[k].pcs; e_condex = tbl[k].cx;
            @(negedge clk);
            got = {f_stall_f, f_stall_d, f_flush_d, f_flush_e, f_fwd_e, f_byp_d, f_redirect};
            chk($sformatf("vec%0d", k), got, tbl[k].exp);
            step();
        end

        // no-forwarding mode: ADD r1 ; SUB r2,r1,r1 stalls until ADD retires
        reset = 1'b0;
        drive(0, 8'h00, 2'b00, 0, 0, 0);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("nf_reset", {n_stall_f, n_stall_d, n_flush_d, n_flush_e, n_fwd_e, n_byp_d, n_redirect}, Z);
        step();
        drive(1, 8'h32, 2'b11, 1, 1, 0);
        @(negedge clk);
        chk("nf_add", {n_stall_f, n_stall_d, n_flush_d, n_flush_e, n_fwd_e, n_byp_d, n_redirect}, Z);
        step();
        drive(1, 8'h11, 2'b11, 2, 1, 0);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!n_stall_f) break;
            chk($sformatf("nf_stall%0d", n),
                {n_stall_f, n_stall_d, n_flush_d, n_flush_e, n_fwd_e, n_byp_d, n_redirect}, STALL);
            n++;
            step();
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL nf_stall_count got %0d expected 3", n);
        end
        step();
        drive(0, 8'h00, 2'b00, 0, 0, 0);
        repeat (3) step();

        // r15 producer then r15 reader: no stall in either mode
        drive(1, 8'h02, 2'b01, 15, 1, 1);
        step();
        drive(1, 8'hFF, 2'b11, 3, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("pc_fwd%0d", k), {10'b0, f_stall_f}, Z);
            chk($sformatf("pc_nf%0d", k), {10'b0, n_stall_f}, Z);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
